// File: rtl/mio_bus_bridge_if.sv
// rtl/mio_bus_bridge_if.sv - CPU-side and device-side signal bundle for mio_bus_bridge
interface mio_bus_bridge_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr_bus;
   logic [31:0] Data_out;
   logic [31:0] Data_in;
   logic        MIO_ready;
   logic        dev_req;
   logic        dev_we;
   logic [31:0] dev_addr;
   logic [31:0] dev_wdata;
   logic [31:0] dev_rdata;
   logic        dev_ack;
   logic        bus_err;
   logic [1:0]  state_out;

   // Bridge view: takes CPU requests and device responses, drives the device bus
   modport master (
      input  MemRead, MemWrite, addr_bus, Data_out, dev_rdata, dev_ack,
      output Data_in, MIO_ready, dev_req, dev_we, dev_addr, dev_wdata, bus_err, state_out
   );

   // Environment view: CPU plus device model
   modport slave (
      output MemRead, MemWrite, addr_bus, Data_out, dev_rdata, dev_ack,
      input  Data_in, MIO_ready, dev_req, dev_we, dev_addr, dev_wdata, bus_err, state_out
   );
endinterface

// File: rtl/mio_bus_bridge.sv
// rtl/mio_bus_bridge.sv - CPU to device request/ack bridge; optional timeout abort under MIO_TIMEOUT_EN
module mio_bus_bridge #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input logic             clk,
   input logic             reset,
   mio_bus_bridge_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t      state;
   logic        dev_req;
   logic        dev_we;
   logic        mio_ready;
   logic [31:0] dev_addr;
   logic [31:0] dev_wdata;
   logic [31:0] data_in;

`ifdef MIO_TIMEOUT_EN
   logic [7:0]  wait_cnt;
   logic        bus_err;

   // Timeout counter and sticky error flag; cleared only by reset or the illegal-state recovery
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 8'd0;
         bus_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: wait_cnt <= 8'd0;
            REQ: begin
               // An ack in the same cycle as expiry wins, so the error is only raised without ack
               if (!bus.dev_ack) begin
                  if (wait_cnt == TIMEOUT - 8'd1) bus_err <= 1'b1;
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE: wait_cnt <= 8'd0;
            default: begin
               wait_cnt <= 8'd0;
               bus_err  <= 1'b0;
            end
         endcase
      end
   end

   logic timed_out;
   assign timed_out = !bus.dev_ack && (wait_cnt == TIMEOUT - 8'd1);
`else
   logic unused_timeout;
   logic timed_out;
   logic bus_err;
   assign unused_timeout = ^TIMEOUT;
   assign timed_out      = 1'b0;
   assign bus_err        = 1'b0;
`endif

   // Main transaction FSM with all outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         dev_req   <= 1'b0;
         dev_we    <= 1'b0;
         mio_ready <= 1'b0;
         dev_addr  <= 32'h0;
         dev_wdata <= 32'h0;
         data_in   <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               mio_ready <= 1'b0;
               if (bus.MemRead || bus.MemWrite) begin
                  dev_addr  <= bus.addr_bus;
                  dev_wdata <= bus.Data_out;
                  dev_we    <= bus.MemWrite;
                  dev_req   <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               // CPU inputs are deliberately not looked at here; the latched request stays stable
               if (bus.dev_ack) begin
                  dev_req   <= 1'b0;
                  mio_ready <= 1'b1;
                  if (!dev_we) data_in <= bus.dev_rdata;
                  state     <= DONE;
               end else if (timed_out) begin
                  dev_req   <= 1'b0;
                  mio_ready <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               mio_ready <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               state     <= IDLE;
               dev_req   <= 1'b0;
               dev_we    <= 1'b0;
               mio_ready <= 1'b0;
               dev_addr  <= 32'h0;
               dev_wdata <= 32'h0;
               data_in   <= 32'h0;
            end
         endcase
      end
   end

   assign bus.Data_in   = data_in;
   assign bus.MIO_ready = mio_ready;
   assign bus.dev_req   = dev_req;
   assign bus.dev_we    = dev_we;
   assign bus.dev_addr  = dev_addr;
   assign bus.dev_wdata = dev_wdata;
   assign bus.bus_err   = bus_err;
   assign bus.state_out = state;

endmodule

// File: tb/tb_mio_bus_bridge.sv
// tb/tb_mio_bus_bridge.sv - directed-vector bench for mio_bus_bridge
module tb_mio_bus_bridge;
   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   mio_bus_bridge_if bus ();

   mio_bus_bridge #(.TIMEOUT(8'd4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int seen_drop;
      int seen_rdy;
      int seen_err;
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.addr_bus  = 32'h0;
      bus.Data_out  = 32'h0;
      bus.dev_rdata = 32'h0;
      bus.dev_ack   = 1'b0;
      tick();
      tick();
      check_eq("rst_state", {30'h0, bus.state_out}, 32'h0);
      check_eq("rst_req", {31'h0, bus.dev_req}, 32'h0);
      check_eq("rst_addr", bus.dev_addr, 32'h0);
      check_eq("rst_din", bus.Data_in, 32'h0);
      reset = 1'b0;

      // ack while idle without request is ignored
      bus.dev_ack = 1'b1;
      tick();
      check_eq("idle_ack_state", {30'h0, bus.state_out}, 32'h0);
      check_eq("idle_ack_rdy", {31'h0, bus.MIO_ready}, 32'h0);
      bus.dev_ack = 1'b0;

      // read with immediate ack
      bus.MemRead  = 1'b1;
      bus.addr_bus = 32'h0000_0004;
      tick();
      check_eq("rd_state_req", {30'h0, bus.state_out}, 32'h1);
      check_eq("rd_req", {31'h0, bus.dev_req}, 32'h1);
      check_eq("rd_we", {31'h0, bus.dev_we}, 32'h0);
      check_eq("rd_addr", bus.dev_addr, 32'h0000_0004);
      bus.dev_ack   = 1'b1;
      bus.dev_rdata = 32'h2010_0001;
      tick();
      check_eq("rd_rdy", {31'h0, bus.MIO_ready}, 32'h1);
      check_eq("rd_req_drop", {31'h0, bus.dev_req}, 32'h0);
      check_eq("rd_din", bus.Data_in, 32'h2010_0001);
      check_eq("rd_state_done", {30'h0, bus.state_out}, 32'h2);
      bus.MemRead = 1'b0;
      bus.dev_ack = 1'b0;
      tick();
      check_eq("rd_rdy_pulse", {31'h0, bus.MIO_ready}, 32'h0);
      check_eq("rd_back_idle", {30'h0, bus.state_out}, 32'h0);

      // write with three wait cycles; CPU inputs change during REQ and must be ignored
      bus.MemWrite = 1'b1;
      bus.addr_bus = 32'h0000_0008;
      bus.Data_out = 32'hA5A5_5A5A;
      tick();
      bus.addr_bus = 32'h1111_1111;
      bus.Data_out = 32'h2222_2222;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("wr_req_c%0d", i), {31'h0, bus.dev_req}, 32'h1);
         check_eq($sformatf("wr_we_c%0d", i), {31'h0, bus.dev_we}, 32'h1);
         check_eq($sformatf("wr_wdata_c%0d", i), bus.dev_wdata, 32'hA5A5_5A5A);
         check_eq($sformatf("wr_addr_c%0d", i), bus.dev_addr, 32'h0000_0008);
         check_eq($sformatf("wr_rdy_c%0d", i), {31'h0, bus.MIO_ready}, 32'h0);
         if (i == 3) bus.dev_ack = 1'b1;
         bus.dev_rdata = 32'hDEAD_BEEF;
         tick();
      end
      bus.dev_ack = 1'b0;
      check_eq("wr_rdy", {31'h0, bus.MIO_ready}, 32'h1);
      check_eq("wr_din_kept", bus.Data_in, 32'h2010_0001);
      // MemWrite still held: back-to-back request passes through IDLE first
      tick();
      check_eq("b2b_idle_state", {30'h0, bus.state_out}, 32'h0);
      check_eq("b2b_idle_req", {31'h0, bus.dev_req}, 32'h0);
      check_eq("b2b_rdy_off", {31'h0, bus.MIO_ready}, 32'h0);
      tick();
      check_eq("b2b_req", {31'h0, bus.dev_req}, 32'h1);
      check_eq("b2b_addr", bus.dev_addr, 32'h1111_1111);
      check_eq("b2b_wdata", bus.dev_wdata, 32'h2222_2222);
      bus.MemWrite = 1'b0;
      bus.dev_ack  = 1'b1;
      tick();
      bus.dev_ack  = 1'b0;
      tick();

      // simultaneous read and write: write wins
      bus.MemRead  = 1'b1;
      bus.MemWrite = 1'b1;
      bus.addr_bus = 32'h0000_0010;
      tick();
      check_eq("both_we", {31'h0, bus.dev_we}, 32'h1);
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.dev_ack   = 1'b1;
      bus.dev_rdata = 32'h7777_7777;
      tick();
      check_eq("both_din_kept", bus.Data_in, 32'h2010_0001);
      bus.dev_ack = 1'b0;
      tick();

      // reset in the middle of REQ
      bus.MemRead  = 1'b1;
      bus.addr_bus = 32'h0000_0020;
      tick();
      check_eq("mid_pre_req", {31'h0, bus.dev_req}, 32'h1);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_req", {31'h0, bus.dev_req}, 32'h0);
      check_eq("mid_rst_state", {30'h0, bus.state_out}, 32'h0);
      check_eq("mid_rst_din", bus.Data_in, 32'h0);
      check_eq("mid_rst_addr", bus.dev_addr, 32'h0);
      bus.MemRead = 1'b0;
      bus.dev_ack = 1'b1;
      tick();
      reset = 1'b0;
      seen_rdy = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.MIO_ready) seen_rdy++;
         tick();
      end
      check_eq("mid_rst_no_rdy", seen_rdy, 0);
      check_eq("mid_rst_idle", {30'h0, bus.state_out}, 32'h0);
      bus.dev_ack = 1'b0;

`ifdef MIO_TIMEOUT_EN
      // ack on the last allowed cycle wins over the timeout
      bus.MemRead   = 1'b1;
      bus.addr_bus  = 32'h0000_0030;
      tick();
      bus.MemRead   = 1'b0;
      tick();
      tick();
      tick();
      bus.dev_ack   = 1'b1;
      bus.dev_rdata = 32'h0000_0ACE;
      tick();
      bus.dev_ack   = 1'b0;
      check_eq("to_race_rdy", {31'h0, bus.MIO_ready}, 32'h1);
      check_eq("to_race_err", {31'h0, bus.bus_err}, 32'h0);
      check_eq("to_race_din", bus.Data_in, 32'h0000_0ACE);
      tick();

      // no ack: abort after four REQ cycles
      bus.MemRead = 1'b1;
      tick();
      bus.MemRead = 1'b0;
      seen_drop = 0;
      for (int i = 0; i < 4; i++) begin
         if (!bus.dev_req || bus.MIO_ready) seen_drop++;
         tick();
      end
      check_eq("to_held4", seen_drop, 0);
      check_eq("to_rdy", {31'h0, bus.MIO_ready}, 32'h1);
      check_eq("to_req_drop", {31'h0, bus.dev_req}, 32'h0);
      check_eq("to_err", {31'h0, bus.bus_err}, 32'h1);
      check_eq("to_din_kept", bus.Data_in, 32'h0000_0ACE);
      tick();
      bus.MemRead   = 1'b1;
      tick();
      bus.MemRead   = 1'b0;
      bus.dev_ack   = 1'b1;
      bus.dev_rdata = 32'h0BAD_F00D;
      tick();
      bus.dev_ack   = 1'b0;
      check_eq("to_good_din", bus.Data_in, 32'h0BAD_F00D);
      check_eq("to_err_sticky", {31'h0, bus.bus_err}, 32'h1);
      tick();
`else
      // no ack for 1000 cycles: request held, never completes, no error
      bus.MemRead  = 1'b1;
      bus.addr_bus = 32'h0000_0040;
      tick();
      bus.MemRead  = 1'b0;
      seen_drop = 0;
      seen_rdy  = 0;
      seen_err  = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!bus.dev_req) seen_drop++;
         if (bus.MIO_ready) seen_rdy++;
         if (bus.bus_err) seen_err++;
         tick();
      end
      check_eq("noack_req_held", seen_drop, 0);
      check_eq("noack_no_rdy", seen_rdy, 0);
      check_eq("noack_no_err", seen_err, 0);
      bus.dev_ack   = 1'b1;
      bus.dev_rdata = 32'h0000_1234;
      tick();
      bus.dev_ack   = 1'b0;
      check_eq("noack_late_rdy", {31'h0, bus.MIO_ready}, 32'h1);
      check_eq("noack_late_din", bus.Data_in, 32'h0000_1234);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
